// File: rtl/vrf_write_addr_gen.sv
// VRF write-side address / byte-enable generator for one lane's register-file bank.
// Packs result elements into byte lanes and walks the register group bases like the read side.
module vrf_write_addr_gen #(
    parameter int MEM_DEPTH         = 512,
    parameter int VREG_LOC_PER_LANE = 8,
    localparam int AW               = $clog2(MEM_DEPTH),
    localparam int MAX_EL           = 8 * VREG_LOC_PER_LANE * 4,
    localparam int CW               = $clog2(MAX_EL + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [8*AW-1:0] start_addr_i,
    input  logic [1:0]      element_width_i,
    input  logic [CW-1:0]   el_count_i,
    input  logic            load_i,
    input  logic [31:0]     data_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic            wen_o,
    output logic [AW-1:0]   waddr_o,
    output logic [31:0]     wdata_o,
    output logic [3:0]      wbe_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int SW = $clog2(4 * VREG_LOC_PER_LANE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      width_q, width_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [8*AW-1:0] base_q, base_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wbe_q, wbe_d;

    logic            accept;
    logic            load_ok;
    logic [CW-1:0]   count_sat;
    logic [SW-1:0]   limit;
    logic [AW-1:0]   base0;
    logic [AW-1:0]   word_off;

    assign accept    = valid_i && (state_q == RUN);
    assign load_ok   = load_i && (element_width_i != 2'b11);
    assign count_sat = (el_count_i > CW'(MAX_EL)) ? CW'(MAX_EL) : el_count_i;
    assign base0     = base_q[AW-1:0];

    always_comb begin
        case (width_q)
            2'b00:   limit = SW'(4 * VREG_LOC_PER_LANE - 1);
            2'b01:   limit = SW'(2 * VREG_LOC_PER_LANE - 1);
            default: limit = SW'(VREG_LOC_PER_LANE - 1);
        endcase
    end

    // A restart load wins over an element accepted in the same cycle; that element is dropped.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wen_d       = 1'b0;
        wbe_d       = 4'b0000;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        word_off    = '0;

        if (load_ok) begin
            width_d     = element_width_i;
            remaining_d = count_sat;
            cnt_d       = '0;
            base_d      = start_addr_i;
            state_d     = (count_sat == '0) ? DONE : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        case (width_q)
                            2'b00: begin
                                word_off = AW'(cnt_q >> 2);
                                wbe_d    = 4'b0001 << cnt_q[1:0];
                                wdata_d  = {4{data_i[7:0]}};
                            end
                            2'b01: begin
                                word_off = AW'(cnt_q >> 1);
                                wbe_d    = cnt_q[0] ? 4'b1100 : 4'b0011;
                                wdata_d  = {2{data_i[15:0]}};
                            end
                            default: begin
                                word_off = AW'(cnt_q);
                                wbe_d    = 4'b1111;
                                wdata_d  = data_i;
                            end
                        endcase
                        wen_d       = 1'b1;
                        waddr_d     = base0 + word_off;
                        remaining_d = remaining_q - CW'(1);
                        if (cnt_q == limit) begin
                            cnt_d  = '0;
                            base_d = {{AW{1'b0}}, base_q[8*AW-1:AW]};
                        end else begin
                            cnt_d = cnt_q + SW'(1);
                        end
                        if (remaining_q == CW'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            width_q     <= 2'b00;
            remaining_q <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wbe_q       <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wbe_q       <= wbe_d;
        end
    end

    assign ready_o = (state_q == RUN);
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign wen_o   = wen_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign wbe_o   = wbe_q;

endmodule

// File: tb/tb_vrf_write_addr_gen.sv
// Testbench for vrf_write_addr_gen: directed scenarios plus randomized transactions
// compared cycle by cycle against an element-index based reference model.
module tb_vrf_write_addr_gen;

    localparam int MEM_DEPTH = 512;
    localparam int LOC       = 8;
    localparam int AW        = 9;
    localparam int MAX_EL    = 256;
    localparam int CW        = 9;

    logic            clk_i;
    logic            rst_i;
    logic [8*AW-1:0] start_addr_i;
    logic [1:0]      element_width_i;
    logic [CW-1:0]   el_count_i;
    logic            load_i;
    logic [31:0]     data_i;
    logic            valid_i;
    logic            ready_o;
    logic            wen_o;
    logic [AW-1:0]   waddr_o;
    logic [31:0]     wdata_o;
    logic [3:0]      wbe_o;
    logic            busy_o;
    logic            done_o;

    vrf_write_addr_gen #(
        .MEM_DEPTH        (MEM_DEPTH),
        .VREG_LOC_PER_LANE(LOC)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_addr_i   (start_addr_i),
        .element_width_i(element_width_i),
        .el_count_i     (el_count_i),
        .load_i         (load_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .wen_o          (wen_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o),
        .wbe_o          (wbe_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: tracks the element index of the transaction, not any counter encoding.
    bit          mBusy;
    int          mIdx;
    int          mTotal;
    int          mWidth;
    int          mBase[8];
    logic        eWen;
    logic        eDone;
    logic [AW-1:0] eAddr;
    logic [31:0] eData;
    logic [3:0]  eBe;

    logic [AW-1:0] logAddr[$];
    logic [3:0]    logBe[$];
    logic [31:0]   logData[$];
    logic          logDone[$];
    int            doneSeen;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mBusy  = 1'b0;
        mIdx   = 0;
        mTotal = 0;
        mWidth = 0;
        for (int k = 0; k < 8; k++) mBase[k] = 0;
        eWen  = 1'b0;
        eDone = 1'b0;
        eAddr = '0;
        eData = '0;
        eBe   = '0;
    endtask

    task automatic modelStep(input logic ld, input logic [1:0] w, input int cnt,
                             input logic [8*AW-1:0] bases, input logic v, input logic [31:0] d);
        int epw, regIdx, j, base, lane;
        eWen  = 1'b0;
        eBe   = 4'b0000;
        eDone = 1'b0;
        if (ld && w != 2'b11) begin
            mWidth = int'(w);
            mTotal = (cnt > MAX_EL) ? MAX_EL : cnt;
            mIdx   = 0;
            for (int k = 0; k < 8; k++) mBase[k] = int'(bases[k*AW +: AW]);
            if (mTotal == 0) begin
                mBusy = 1'b0;
                eDone = 1'b1;
            end else begin
                mBusy = 1'b1;
            end
        end else if (mBusy && v) begin
            epw    = 4 >> mWidth;
            regIdx = mIdx / (LOC * epw);
            j      = mIdx % (LOC * epw);
            base   = (regIdx < 8) ? mBase[regIdx] : 0;
            lane   = j % epw;
            eAddr  = AW'((base + j / epw) % MEM_DEPTH);
            case (mWidth)
                0: begin eBe = 4'(1 << lane); eData = {4{d[7:0]}}; end
                1: begin eBe = (lane == 1) ? 4'hC : 4'h3; eData = {2{d[15:0]}}; end
                default: begin eBe = 4'hF; eData = d; end
            endcase
            eWen = 1'b1;
            mIdx++;
            if (mIdx == mTotal) begin
                mBusy = 1'b0;
                eDone = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("wen", 32'(wen_o), 32'(eWen));
        checkOutput("waddr", 32'(waddr_o), 32'(eAddr));
        checkOutput("wdata", wdata_o, eData);
        checkOutput("wbe", 32'(wbe_o), 32'(eBe));
        checkOutput("done", 32'(done_o), 32'(eDone));
        checkOutput("busy", 32'(busy_o), 32'(mBusy));
        checkOutput("ready", 32'(ready_o), 32'(mBusy));
        if (wen_o === 1'b1) begin
            logAddr.push_back(waddr_o);
            logBe.push_back(wbe_o);
            logData.push_back(wdata_o);
            logDone.push_back(done_o);
        end
        if (done_o === 1'b1) doneSeen++;
    endtask

    // Called at a falling edge: check the state left by the last rising edge, then drive the next one.
    task automatic applyStimulus(input logic ld, input logic [1:0] w, input int cnt,
                                 input logic [8*AW-1:0] bases, input logic v, input logic [31:0] d);
        checkAll();
        load_i          = ld;
        element_width_i = w;
        el_count_i      = CW'(cnt);
        start_addr_i    = bases;
        valid_i         = v;
        data_i          = d;
        modelStep(ld, w, cnt, bases, v, d);
        @(negedge clk_i);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 0, '0, 1'b0, 32'h0);
    endtask

    task automatic clearLog();
        logAddr.delete();
        logBe.delete();
        logData.delete();
        logDone.delete();
        doneSeen = 0;
    endtask

    function automatic logic [8*AW-1:0] makeBases(input int b0, input int b1);
        logic [8*AW-1:0] b;
        b = '0;
        b[0 +: AW]  = AW'(b0);
        b[AW +: AW] = AW'(b1);
        for (int k = 2; k < 8; k++) b[k*AW +: AW] = AW'(64 * k);
        return b;
    endfunction

    function automatic logic [8*AW-1:0] randomBases();
        logic [8*AW-1:0] b;
        for (int k = 0; k < 8; k++) b[k*AW +: AW] = AW'($urandom_range(0, MEM_DEPTH - 1));
        return b;
    endfunction

    initial begin
        int byteAddr[6] = '{16, 16, 16, 16, 17, 17};
        int byteBe[6]   = '{1, 2, 4, 8, 1, 2};
        int hwAddr[3]   = '{100, 100, 101};
        int hwBe[3]     = '{3, 12, 3};
        int hwData[3]   = '{32'h12341234, 32'h56785678, 32'h9ABC9ABC};
        int wordAddr[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 40, 41};
        logic [1:0] rw;
        int rc;

        rst_i           = 1'b1;
        load_i          = 1'b0;
        element_width_i = 2'b00;
        el_count_i      = '0;
        start_addr_i    = '0;
        valid_i         = 1'b0;
        data_i          = '0;
        modelReset();
        clearLog();
        #1;
        checkAll();
        @(negedge clk_i);
        rst_i = 1'b0;
        clearLog();

        $display("[TB] byte packing");
        applyStimulus(1'b1, 2'b00, 6, makeBases(16, 30), 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'hA1 + 32'(i));
        idleCycles(3);
        checkOutput("byteWrites", 32'(logAddr.size()), 32'd6);
        for (int i = 0; i < 6 && i < logAddr.size(); i++) begin
            checkOutput("byteAddr", 32'(logAddr[i]), 32'(byteAddr[i]));
            checkOutput("byteBe", 32'(logBe[i]), 32'(byteBe[i]));
        end
        if (logData.size() > 0) checkOutput("byteData0", logData[0], 32'hA1A1A1A1);
        if (logDone.size() == 6) checkOutput("byteDoneLast", 32'(logDone[5]), 32'd1);
        checkOutput("byteDonePulses", 32'(doneSeen), 32'd1);

        $display("[TB] halfword packing");
        clearLog();
        applyStimulus(1'b1, 2'b01, 3, makeBases(100, 7), 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'h1234);
        applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'h5678);
        applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'h9ABC);
        idleCycles(2);
        checkOutput("hwWrites", 32'(logAddr.size()), 32'd3);
        for (int i = 0; i < 3 && i < logAddr.size(); i++) begin
            checkOutput("hwAddr", 32'(logAddr[i]), 32'(hwAddr[i]));
            checkOutput("hwBe", 32'(logBe[i]), 32'(hwBe[i]));
            checkOutput("hwData", logData[i], 32'(hwData[i]));
        end

        $display("[TB] word crossing registers");
        clearLog();
        applyStimulus(1'b1, 2'b10, 10, makeBases(0, 40), 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, $urandom());
        idleCycles(2);
        checkOutput("wordWrites", 32'(logAddr.size()), 32'd10);
        for (int i = 0; i < 10 && i < logAddr.size(); i++) begin
            checkOutput("wordAddr", 32'(logAddr[i]), 32'(wordAddr[i]));
            checkOutput("wordBe", 32'(logBe[i]), 32'hF);
        end

        $display("[TB] gapped valid");
        clearLog();
        applyStimulus(1'b1, 2'b10, 4, makeBases(200, 210), 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 2'b00, 0, '0, (i % 3 == 2), $urandom());
        idleCycles(2);
        checkOutput("gapWrites", 32'(logAddr.size()), 32'd4);

        $display("[TB] zero count and illegal width");
        clearLog();
        applyStimulus(1'b1, 2'b00, 0, makeBases(5, 6), 1'b0, 32'h0);
        idleCycles(3);
        checkOutput("zeroWrites", 32'(logAddr.size()), 32'd0);
        checkOutput("zeroDone", 32'(doneSeen), 32'd1);
        applyStimulus(1'b1, 2'b11, 5, makeBases(5, 6), 1'b1, 32'h0);
        idleCycles(3);
        checkOutput("illegalBusy", 32'(busy_o), 32'd0);
        checkOutput("illegalWrites", 32'(logAddr.size()), 32'd0);

        $display("[TB] saturation");
        clearLog();
        applyStimulus(1'b1, 2'b00, 300, makeBases(10, 50), 1'b0, 32'h0);
        for (int i = 0; i < 262; i++) applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, $urandom());
        idleCycles(2);
        checkOutput("satWrites", 32'(logAddr.size()), 32'd256);

        $display("[TB] restart drops same-cycle element");
        clearLog();
        applyStimulus(1'b1, 2'b10, 6, makeBases(80, 90), 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'h11);
        applyStimulus(1'b1, 2'b10, 2, makeBases(120, 90), 1'b1, 32'h22);
        applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'h33);
        applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'h44);
        idleCycles(2);
        checkOutput("restartWrites", 32'(logAddr.size()), 32'd3);
        if (logAddr.size() == 3) checkOutput("restartAddr", 32'(logAddr[1]), 32'd120);

        $display("[TB] async reset mid-run");
        clearLog();
        applyStimulus(1'b1, 2'b10, 8, makeBases(200, 300), 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'hC0 + 32'(i));
        checkAll();
        rst_i = 1'b1;
        #1;
        checkOutput("rstWen", 32'(wen_o), 32'd0);
        checkOutput("rstBusy", 32'(busy_o), 32'd0);
        checkOutput("rstAddr", 32'(waddr_o), 32'd0);
        checkOutput("rstData", wdata_o, 32'd0);
        checkOutput("rstBe", 32'(wbe_o), 32'd0);
        modelReset();
        @(negedge clk_i);
        rst_i = 1'b0;
        clearLog();
        applyStimulus(1'b1, 2'b10, 2, makeBases(300, 310), 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'h1);
        applyStimulus(1'b0, 2'b00, 0, '0, 1'b1, 32'h2);
        idleCycles(2);
        checkOutput("postRstWrites", 32'(logAddr.size()), 32'd2);
        if (logAddr.size() == 2) checkOutput("postRstAddr0", 32'(logAddr[0]), 32'd300);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 40; t++) begin
            rw = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rc = ($urandom_range(0, 9) == 0) ? $urandom_range(257, 300) : $urandom_range(0, 48);
            applyStimulus(1'b1, rw, rc, randomBases(), $urandom_range(0, 1) == 1, $urandom());
            for (int c = 0; c < 600 && mBusy; c++) begin
                if ($urandom_range(0, 39) == 0) begin
                    rw = 2'($urandom_range(0, 2));
                    applyStimulus(1'b1, rw, $urandom_range(1, 24), randomBases(), 1'b1, $urandom());
                end else begin
                    applyStimulus(1'b0, 2'b00, 0, '0, $urandom_range(0, 3) != 0, $urandom());
                end
            end
            idleCycles(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vrf_write_addr_gen.md
Name: vrf_write_addr_gen

Overview:
- Write-side address and byte-enable generator for one vector lane's register-file bank.
- Accepts a stream of result elements from the lane ALU/load path.
- Packs each element into its byte lane of a 32-bit VRF word.
- Issues registered write address, data and byte-enables.
- Walks the up to 8 register bases of a register group, in the same element-to-location ordering the read-side address counter uses. Reads and writes of the same register group therefore line up element for element.

Parameters:
- MEM_DEPTH, 512, VRF bank depth in 32-bit words; AW = $clog2(MEM_DEPTH).
- VREG_LOC_PER_LANE, 8, words per vector register per lane.
- Derived: MAX_EL = 8*VREG_LOC_PER_LANE*4; CW = $clog2(MAX_EL+1).

Ports:
- clk_i  in  1  clock, all state on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- start_addr_i  in  8*AW  base word address of registers 0..7 of the group; register k in bits [k*AW +: AW].
- element_width_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- el_count_i  in  CW  number of elements this lane writes.
- load_i  in  1  start pulse; latches start_addr_i, element_width_i, el_count_i.
- data_i  in  32  element, right-aligned.
- valid_i  in  1  data_i valid.
- ready_o  out  1  element accepted when valid_i & ready_o.
- wen_o  out  1  VRF write strobe.
- waddr_o  out  AW  VRF write address.
- wdata_o  out  32  element replicated into its byte lane(s).
- wbe_o  out  4  byte write enables.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_i=1): state IDLE, all counters 0, base shift register 0, all outputs 0.

States and transitions:
- IDLE -> RUN on load_i when element_width_i != 11 and el_count_i != 0.
- IDLE -> DONE on load_i with el_count_i = 0.
- load_i with element_width_i = 11 is ignored; state stays IDLE.
- RUN -> DONE the cycle the last element is accepted.
- DONE -> IDLE after one cycle; done_o = 1 only in DONE.
- load_i in RUN or DONE restarts: relatch all inputs, go to RUN. Any element accepted in that same cycle is discarded.

Handshake and counting:
- ready_o = busy_o = (state == RUN); valid_i may gap arbitrarily.
- el_count_i > MAX_EL saturates to MAX_EL at load.
- Sub-counter cnt counts accepted elements within the current register. Its limit is:
  - 4*LOC-1 for byte.
  - 2*LOC-1 for halfword.
  - LOC-1 for word.
- Word offset within the register: cnt>>2 (byte), cnt>>1 (halfword), cnt (word).
- Byte lane: cnt[1:0] (byte), cnt[0] (halfword).
- When an element is accepted with cnt = limit: cnt -> 0 and the base shift register shifts by one (base[k] <= base[k+1], base[7] <= 0).
- Address arithmetic is modulo 2^AW; wrap-around is allowed, not flagged.

Output timing:
- Latency 1: for an element accepted at cycle n, wen_o=1 at n+1 with:
  - waddr_o = base[0] + word_offset;
  - wbe_o / wdata_o, from data byte d0 and halfword h0:
    - byte, lane b: wbe_o = 1<<b, wdata_o = {4{d0}}.
    - halfword, lane h: wbe_o = 0011 or 1100, wdata_o = {2{h0}}.
    - word: wbe_o = 1111, wdata_o = data_i.
- With no acceptance, wen_o = 0 and wbe_o = 0. waddr_o and wdata_o hold their last values.
- The last write and the done_o pulse appear in the same cycle.

Test Plan:
- Byte: base0=16, el_count=6, data 0xA1..0xA6 back-to-back. Writes must be:
  - addr 16, wbe 0001,0010,0100,1000;
  - addr 17, wbe 0001,0010;
  - wdata of the first write = 0xA1A1A1A1;
  - done_o with the 6th write.
- Halfword: base0=100, el_count=3, data 0x1234,0x5678,0x9ABC. Writes must be:
  - (100, 0011, 0x12341234), (100, 1100, 0x56785678), (101, 0011, 0x9ABC9ABC).
- Word crossing registers: base0=0, base1=40, el_count=10. Writes must go to addresses 0..7 then 40, 41, all wbe 1111.
- Gapped valid: word, el_count=4, valid_i high every third cycle.
  - Exactly 4 writes, each 1 cycle after its acceptance.
  - ready_o stays 1 until the last acceptance.
- Boundaries:
  - el_count=0: done_o pulses 1 cycle after load_i, no wen_o.
  - element_width=11: load_i ignored, busy_o stays 0.
  - el_count=300 with LOC=8: saturates to 256 elements.
- Async reset mid-RUN after 3 elements: outputs go 0 immediately, no clock edge needed. A following load_i restarts at cnt=0, base0.
